memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter MAX_DATA_STREAK, default 4: maximum consecutive data grants while an instruction request is pending; legal range 1-15.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately, regardless of clk.
REQ-004 i_req  in  1  instruction fetch request; held high until i_ack.
REQ-005 i_addr  in  32  instruction byte address; sampled at grant.
REQ-006 i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-007 i_rdata  out  32  fetched word; valid in the i_ack cycle only.
REQ-008 d_req  in  1  data request; held high until d_ack.
REQ-009 d_we  in  1  1 = write, 0 = read.
REQ-010 d_addr  in  32  data byte address.
REQ-011 d_mask  in  4  byte-lane frame mask, bit 3 = byte [7:0] ... bit 0 = byte [31:24].
REQ-012 d_wdata  in  32  write data.
REQ-013 d_ack  out  1  one-cycle pulse: data access complete, d_rdata valid for reads.
REQ-014 d_rdata  out  32  read word; valid in the d_ack cycle only.
REQ-015 m_req, m_we, m_addr[31:0], m_mask[3:0], m_wdata[31:0]  out  shared memory request bundle.
REQ-016 m_ready  in  1  memory completes the current access in this cycle.
REQ-017 m_rdata  in  32  memory read data; valid when m_ready = 1.
REQ-018 grant  out  2  00 none, 01 instruction, 10 data; reflects the owner of the memory port.

Function
REQ-019 FSM states: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
REQ-020 IDLE: no request -> stay; only d_req -> SERVE_D; only i_req -> SERVE_I; both -> SERVE_D unless the streak counter = MAX_DATA_STREAK, then SERVE_I.
REQ-021 On leaving IDLE, the grantee's address, mask, we and wdata are latched into registers; the m_* outputs are driven from these registers only. Instruction grants drive m_we = 0 and m_mask = 4'b1111.
REQ-022 SERVE_x: m_req = 1 and the bundle is held stable; on m_ready = 1, m_rdata is registered and the FSM moves to DONE_x; otherwise the FSM stays in SERVE_x with no timeout.
REQ-023 DONE_x: the matching ack = 1 for exactly one cycle with rdata valid, m_req = 0, then IDLE.
REQ-024 Minimum latency: req high at edge N -> m_req high in cycle N+1 -> ack in cycle N+2 if m_ready = 1 in cycle N+1; 3 cycles per transaction; back-to-back throughput is 1 access per 3 cycles.
REQ-025 Requesters drop or renew req in the cycle after ack; req sampled in IDLE is always treated as a new request.
REQ-026 Streak counter, 4 bits: +1 on each data grant made while i_req = 1; cleared on any instruction grant or any IDLE cycle with i_req = 0; saturates at MAX_DATA_STREAK.
REQ-027 Deassertion of req during SERVE_x or DONE_x is ignored; the access completes and ack still pulses.
REQ-028 Input changes during SERVE_x do not alter the m_* outputs.
REQ-029 i_rdata and d_rdata hold their last value outside ack cycles; consumers ignore them then.
REQ-030 grant = 01 in SERVE_I/DONE_I, 10 in SERVE_D/DONE_D, 00 in IDLE.
REQ-031 i_ack and d_ack are never high in the same cycle; m_req is never high outside SERVE_x.

Reset
REQ-032 reset = 0 forces: state IDLE; streak 0; m_req, m_we, i_ack, d_ack = 0; m_addr, m_mask, m_wdata, i_rdata, d_rdata = 0; grant = 00.
REQ-033 Reset during SERVE_x or DONE_x abandons the access with no ack; after release, the first active edge evaluates IDLE normally.

Verification
REQ-034 Single read: d_req = 1, d_we = 0, d_addr = 0x100, m_ready tied 1, m_rdata = 0xDEADBEEF -> m_req high 1 cycle with m_addr = 0x100; d_ack in cycle N+2 with d_rdata = 0xDEADBEEF.
REQ-035 Contention: i_req and d_req held high, requests renewed after each ack, MAX_DATA_STREAK = 4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-036 Wait states: write to 0x1000_0000 with d_mask = 4'b1000 and d_wdata = 0x41, m_ready low for 5 cycles -> m_* stable for 6 cycles; d_ack 1 cycle after m_ready.
REQ-037 Withdrawal: i_req dropped 1 cycle into SERVE_I -> access completes; i_ack still pulses once.
REQ-038 Async reset: reset = 0 mid-SERVE_D, between clock edges -> m_req and grant = 0 before the next edge; no d_ack; a fresh i_req after release is served in 3 cycles.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter: an instruction port and a data port share one
// memory request bundle. Data wins ties, but after MAX_DATA_STREAK consecutive
// data grants with an instruction fetch waiting, the fetch is served.
module memory_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_mask,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_mask_q, m_mask_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // State, latched request bundle and captured read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'd0;
      m_mask_q  <= 4'd0;
      m_wdata_q <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_mask_q  <= m_mask_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Arbitration, bundle capture and completion sequencing.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_mask_d  = m_mask_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && streak_q == STREAK_MAX)) begin
          state_d   = SERVE_D;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_mask_d  = d_mask;
          m_wdata_d = d_wdata;
          // Only data grants made over a waiting fetch count towards the streak.
          if (i_req)
            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
          else
            streak_d = 4'd0;
        end else if (i_req) begin
          state_d   = SERVE_I;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_mask_d  = 4'b1111;
          m_wdata_d = 32'd0;
          streak_d  = 4'd0;
        end else begin
          streak_d = 4'd0;
        end
      end
      SERVE_I: begin
        if (m_ready) begin
          i_rdata_d = m_rdata;
          state_d   = DONE_I;
        end
      end
      SERVE_D: begin
        if (m_ready) begin
          d_rdata_d = m_rdata;
          state_d   = DONE_D;
        end
      end
      DONE_I:  state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state so reset clears them at once.
  always_comb begin
    m_req = (state_q == SERVE_I) || (state_q == SERVE_D);
    i_ack = (state_q == DONE_I);
    d_ack = (state_q == DONE_D);
    grant = 2'b00;
    if (state_q == SERVE_I || state_q == DONE_I) grant = 2'b01;
    if (state_q == SERVE_D || state_q == DONE_D) grant = 2'b10;
  end

  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_mask  = m_mask_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: inputs change and outputs are checked on
// the falling clock edge, away from the rising edge where the DUT updates.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_mask;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_mask;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic [1:0]  grant;

  int checks_total  = 0;
  int checks_passed = 0;

  memory_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_mask(m_mask),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("check %-14s got=%h exp=%h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [1:0] exp_grant [10];

  initial begin
    exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    reset = 1'b0; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_mask = 4'd0; d_wdata = 32'd0; m_ready = 1'b1; m_rdata = 32'd0;

    // Reset state
    tick(); tick();
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_acks",  32'({i_ack, d_ack}), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_mask", 32'(m_mask), 32'd0);
    reset = 1'b1;
    tick();

    // Single read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_mask = 4'b1111;
    m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
    tick();
    check("rd_m_req",  32'(m_req), 32'd1);
    check("rd_m_addr", m_addr, 32'h100);
    check("rd_m_we",   32'(m_we), 32'd0);
    check("rd_grant",  32'(grant), 32'd2);
    check("rd_no_ack", 32'(d_ack), 32'd0);
    tick();
    check("rd_d_ack",  32'(d_ack), 32'd1);
    check("rd_d_rdata", d_rdata, 32'hDEADBEEF);
    check("rd_m_req_lo", 32'(m_req), 32'd0);
    d_req = 1'b0;
    tick();
    check("rd_idle_ack", 32'(d_ack), 32'd0);
    check("rd_idle_gnt", 32'(grant), 32'd0);

    // Contention: both requesters held high, renewing after every ack
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_mask = 4'b0011; d_wdata = 32'hA5;
    m_rdata = 32'h11110000;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("ct_grant%0d", k), 32'(grant), 32'(exp_grant[k]));
      check($sformatf("ct_addr%0d", k), m_addr, (exp_grant[k] == 2'b01) ? 32'h4 : 32'h200);
      check($sformatf("ct_mask%0d", k), 32'(m_mask), (exp_grant[k] == 2'b01) ? 32'hF : 32'h3);
      tick();
      check($sformatf("ct_ack%0d", k), 32'({i_ack, d_ack}),
            (exp_grant[k] == 2'b01) ? 32'd2 : 32'd1);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    check("ct_idle", 32'(grant), 32'd0);

    // Wait states on a masked write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0000; d_mask = 4'b1000; d_wdata = 32'h41;
    m_ready = 1'b0; m_rdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) m_ready = 1'b1;
      // Disturb the data inputs; the latched bundle must not follow them.
      d_addr = 32'hFFFF_0000 + 32'(k); d_mask = 4'(k); d_wdata = 32'(k); d_we = 1'b0;
      check($sformatf("ws_m_req%0d", k), 32'(m_req), 32'd1);
      check($sformatf("ws_bundle%0d", k), {m_addr[31:28], 3'd0, m_we, m_mask, m_wdata[23:0]},
            {4'h1, 3'd0, 1'b1, 4'b1000, 24'h41});
      check($sformatf("ws_no_ack%0d", k), 32'(d_ack), 32'd0);
    end
    tick();
    check("ws_d_ack", 32'(d_ack), 32'd1);
    check("ws_m_req_lo", 32'(m_req), 32'd0);
    d_req = 1'b0;
    tick();
    check("ws_ack_once", 32'(d_ack), 32'd0);

    // Withdrawal of an instruction request while being served
    i_req = 1'b1; i_addr = 32'h80; m_ready = 1'b0;
    tick();
    check("wd_grant", 32'(grant), 32'd1);
    check("wd_mask",  32'({m_we, m_mask}), 32'h0F);
    check("wd_addr",  m_addr, 32'h80);
    i_req = 1'b0;
    tick();
    check("wd_still", 32'(m_req), 32'd1);
    m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
    tick();
    check("wd_i_ack",   32'(i_ack), 32'd1);
    check("wd_i_rdata", i_rdata, 32'hCAFEF00D);
    tick();
    check("wd_ack_lo1", 32'(i_ack), 32'd0);
    tick();
    check("wd_ack_lo2", 32'(i_ack), 32'd0);
    check("wd_rdata_hold", i_rdata, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; m_ready = 1'b0;
    tick();
    check("ar_serving", 32'(m_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_m_req", 32'(m_req), 32'd0);
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_m_addr", m_addr, 32'd0);
    check("ar_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0; m_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("ar_no_ack", 32'({i_ack, d_ack}), 32'd0);
    i_req = 1'b1; i_addr = 32'h400; m_rdata = 32'h0000_55AA;
    tick();
    check("ar_i_grant", 32'(grant), 32'd1);
    check("ar_i_addr", m_addr, 32'h400);
    tick();
    check("ar_i_ack", 32'(i_ack), 32'd1);
    check("ar_i_rdata", i_rdata, 32'h0000_55AA);
    check("ar_d_ack", 32'(d_ack), 32'd0);
    i_req = 1'b0;
    tick();
    check("ar_idle", 32'(grant), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
